// File: rtl/store_buffer_if.sv
// Bundles the MEM-stage store/load handshake and the data-memory port of the store buffer.
// The slave modport is the buffer; the master modport is the pipeline and memory side.
interface store_buffer_if;
    logic        St_Valid;
    logic [31:0] St_Addr;
    logic [31:0] St_Data;
    logic        St_Ready;
    logic        Stall;
    logic        Ld_Valid;
    logic [31:0] Ld_Addr;
    logic [31:0] Ld_Data;
    logic        Empty;
    logic        Mem_Rd;
    logic        Mem_Wr;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WrData;
    logic [31:0] Mem_RdData;

    modport slave (
        input  St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_RdData,
        output St_Ready, Stall, Ld_Data, Empty, Mem_Rd, Mem_Wr, Mem_Addr, Mem_WrData
    );

    modport master (
        output St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_RdData,
        input  St_Ready, Stall, Ld_Data, Empty, Mem_Rd, Mem_Wr, Mem_Addr, Mem_WrData
    );
endinterface

// File: rtl/store_buffer.sv
// Word-granular FIFO store buffer: drains to memory in load-free cycles and
// forwards the youngest matching buffered store to loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          drain_s;
    logic          st_ready_s;
    logic          push_s;
    logic          fwd_hit_s;
    logic [31:0]   fwd_data_s;
    logic [PW-1:0] fwd_idx_s;
    logic          unused_s;

    // Store address bits [1:0] are ignored for word stores.
    assign unused_s = ^sb.St_Addr[1:0];

    // Handshake, drain decision and next-state pointer/count arithmetic.
    always_comb begin
        drain_s    = (count_q != {CW{1'b0}}) && !sb.Ld_Valid;
        st_ready_s = (count_q != FULL_CNT) || drain_s;
        push_s     = sb.St_Valid && st_ready_s;
        head_d     = drain_s ? head_q + PW'(1) : head_q;
        tail_d     = push_s  ? tail_q + PW'(1) : tail_q;
        case ({push_s, drain_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Forwarding search from oldest to youngest so the youngest hit wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        fwd_idx_s  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx_s] == sb.Ld_Addr[31:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_q[fwd_idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Output muxing for load, drain and idle cycles.
    always_comb begin
        sb.St_Ready   = st_ready_s;
        sb.Stall      = sb.St_Valid && !st_ready_s;
        sb.Empty      = (count_q == {CW{1'b0}});
        sb.Mem_Rd     = 1'b0;
        sb.Mem_Wr     = 1'b0;
        sb.Mem_Addr   = 32'h0000_0000;
        sb.Mem_WrData = 32'h0000_0000;
        sb.Ld_Data    = 32'h0000_0000;
        if (sb.Ld_Valid) begin
            sb.Mem_Rd   = 1'b1;
            sb.Mem_Addr = sb.Ld_Addr;
            sb.Ld_Data  = fwd_hit_s ? fwd_data_s : sb.Mem_RdData;
        end else if (drain_s) begin
            sb.Mem_Wr     = 1'b1;
            sb.Mem_Addr   = {addr_q[head_q], 2'b00};
            sb.Mem_WrData = data_q[head_q];
        end else begin
            sb.Mem_Rd = 1'b0;
        end
    end

    // Buffer state; reset empties the queue and discards pending stores at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 30'h0000_0000;
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_s) begin
                addr_q[tail_q] <= sb.St_Addr[31:2];
                data_q[tail_q] <= sb.St_Data;
            end else begin
                addr_q[tail_q] <= addr_q[tail_q];
                data_q[tail_q] <= data_q[tail_q];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer with hand-written multi-cycle sequences.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    store_buffer_if sb ();
    store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .sb(sb));

    always #5 clk = ~clk;

    typedef struct {
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic        ld_v;
        logic [31:0] ld_a;
        logic [31:0] mrd;
        logic        rdy;
        logic        stall;
        logic        empty;
        logic        rd;
        logic        wr;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ldd;
    } vec_t;

    vec_t vecs [20];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (rst && sb.Mem_Wr) begin
            wr_addr_q.push_back(sb.Mem_Addr);
            wr_data_q.push_back(sb.Mem_WrData);
        end
    end

    function automatic vec_t mk(input logic st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                                input logic ld_v, input logic [31:0] ld_a, input logic [31:0] mrd,
                                input logic rdy, input logic stall, input logic empty,
                                input logic rd, input logic wr, input logic [31:0] maddr,
                                input logic [31:0] mwd, input logic [31:0] ldd);
        vec_t v;
        v.st_v = st_v; v.st_a = st_a; v.st_d = st_d;
        v.ld_v = ld_v; v.ld_a = ld_a; v.mrd = mrd;
        v.rdy = rdy; v.stall = stall; v.empty = empty;
        v.rd = rd; v.wr = wr; v.maddr = maddr; v.mwd = mwd; v.ldd = ldd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                         input logic ld_v, input logic [31:0] ld_a, input logic [31:0] mrd);
        sb.St_Valid = st_v; sb.St_Addr = st_a; sb.St_Data = st_d;
        sb.Ld_Valid = ld_v; sb.Ld_Addr = ld_a; sb.Mem_RdData = mrd;
    endtask

    initial begin
        int k;
        int cyc;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        vecs[0]  = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[1]  = mk(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[2]  = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[4]  = mk(1'b1, 32'h20, 32'hA,        1'b1, 32'h100, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,       32'h1234);
        vecs[5]  = mk(1'b1, 32'h20, 32'hB,        1'b1, 32'h100, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,       32'h1234);
        vecs[6]  = mk(1'b0, 32'h0,  32'h0,        1'b1, 32'h20,  32'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        32'hB);
        vecs[7]  = mk(1'b0, 32'h0,  32'h0,        1'b1, 32'h24,  32'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0,        32'h5555);
        vecs[8]  = mk(1'b0, 32'h0,  32'h0,        1'b1, 32'h22,  32'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 32'h0,        32'hB);
        vecs[9]  = mk(1'b1, 32'h30, 32'h1,        1'b1, 32'h100, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,       32'h0);
        vecs[10] = mk(1'b1, 32'h34, 32'h2,        1'b1, 32'h100, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,       32'h0);
        vecs[11] = mk(1'b1, 32'h38, 32'h3,        1'b1, 32'h100, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,       32'h0);
        vecs[12] = mk(1'b1, 32'h38, 32'h3,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hA,        32'h0);
        vecs[13] = mk(1'b0, 32'h0,  32'h0,        1'b1, 32'h38,  32'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 32'h0,        32'h3);
        vecs[14] = mk(1'b0, 32'h0,  32'h0,        1'b1, 32'h20,  32'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        32'hB);
        vecs[15] = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hB,        32'h0);
        vecs[16] = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 32'h1,        32'h0);
        vecs[17] = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h34, 32'h2,        32'h0);
        vecs[18] = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h38, 32'h3,        32'h0);
        vecs[19] = mk(1'b0, 32'h0,  32'h0,        1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0);

        // Reset held with random store traffic and no loads.
        for (int r = 0; r < 3; r++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom, 1'b0, $urandom, $urandom);
            #1;
            chk($sformatf("rst%0d st_ready", r), {31'h0, sb.St_Ready}, 32'h1);
            chk($sformatf("rst%0d stall", r),    {31'h0, sb.Stall},    32'h0);
            chk($sformatf("rst%0d empty", r),    {31'h0, sb.Empty},    32'h1);
            chk($sformatf("rst%0d mem_wr", r),   {31'h0, sb.Mem_Wr},   32'h0);
            chk($sformatf("rst%0d mem_rd", r),   {31'h0, sb.Mem_Rd},   32'h0);
            chk($sformatf("rst%0d mem_addr", r), sb.Mem_Addr,          32'h0);
            chk($sformatf("rst%0d ld_data", r),  sb.Ld_Data,           32'h0);
            step();
        end
        rst = 1'b1;

        // Vector table: single store, forwarding, full buffer with push+pop, ordered drain.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].st_v, vecs[i].st_a, vecs[i].st_d, vecs[i].ld_v, vecs[i].ld_a, vecs[i].mrd);
            #1;
            chk($sformatf("row%0d st_ready", i), {31'h0, sb.St_Ready}, {31'h0, vecs[i].rdy});
            chk($sformatf("row%0d stall", i),    {31'h0, sb.Stall},    {31'h0, vecs[i].stall});
            chk($sformatf("row%0d empty", i),    {31'h0, sb.Empty},    {31'h0, vecs[i].empty});
            chk($sformatf("row%0d mem_rd", i),   {31'h0, sb.Mem_Rd},   {31'h0, vecs[i].rd});
            chk($sformatf("row%0d mem_wr", i),   {31'h0, sb.Mem_Wr},   {31'h0, vecs[i].wr});
            chk($sformatf("row%0d mem_addr", i), sb.Mem_Addr,   vecs[i].maddr);
            chk($sformatf("row%0d mem_wdata", i), sb.Mem_WrData, vecs[i].mwd);
            chk($sformatf("row%0d ld_data", i),  sb.Ld_Data,    vecs[i].ldd);
            step();
        end

        // Wrap-around: ten stores with loads on alternate cycles, then drain.
        wr_addr_q.delete();
        wr_data_q.delete();
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 100) begin
            drive(1'b1, 32'h40 + 32'(4 * k), 32'h1000 + 32'(k), cyc[0], 32'h200, 32'h0);
            #1;
            if (sb.St_Ready) k++;
            step();
            cyc++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("wrap accepted", 32'(k), 32'd10);
        cyc = 0;
        #1;
        while (!sb.Empty && cyc < 100) begin
            step();
            #1;
            cyc++;
        end
        chk("wrap empty", {31'h0, sb.Empty}, 32'h1);
        chk("wrap writes", 32'(wr_addr_q.size()), 32'd10);
        for (int j = 0; j < 10; j++) begin
            if (j < wr_addr_q.size()) begin
                chk($sformatf("wrap addr%0d", j), wr_addr_q[j], 32'h40 + 32'(4 * j));
                chk($sformatf("wrap data%0d", j), wr_data_q[j], 32'h1000 + 32'(j));
            end
        end
        step();

        // Asynchronous reset in the middle of a drain cycle with three entries buffered.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 32'h80 + 32'(4 * j), 32'h7000 + 32'(j), 1'b1, 32'h300, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("midrst pre mem_wr",   {31'h0, sb.Mem_Wr}, 32'h1);
        chk("midrst pre mem_addr", sb.Mem_Addr, 32'h80);
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        #1;
        chk("midrst mem_wr", {31'h0, sb.Mem_Wr}, 32'h0);
        chk("midrst empty",  {31'h0, sb.Empty},  32'h1);
        step();
        rst = 1'b1;
        for (int j = 0; j < 5; j++) step();
        chk("midrst no writes", 32'(wr_addr_q.size()), 32'd0);
        chk("midrst empty after", {31'h0, sb.Empty}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the MEM pipeline stage and the data memory. Stores from the pipeline are queued in a small FIFO and written to memory in cycles when the memory port is not used by a load. Loads read the memory combinationally, and the youngest matching buffered store overrides the memory data. The MEM stage stalls only when a store arrives while the buffer is full and cannot drain.

## Interface
- DEPTH, 4: number of buffered stores; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (low = reset)
- St_Valid  in  1  MEM stage issues a word store this cycle
- St_Addr  in  32  store byte address; only [31:2] is used
- St_Data  in  32  store data
- St_Ready  out  1  store will be accepted at the next edge
- Stall  out  1  St_Valid && !St_Ready; holds the pipeline
- Ld_Valid  in  1  MEM stage issues a word load this cycle
- Ld_Addr  in  32  load byte address; only [31:2] is used
- Ld_Data  out  32  load result, combinational
- Empty  out  1  no buffered stores
- Mem_Rd  out  1  memory read enable
- Mem_Wr  out  1  memory write enable
- Mem_Addr  out  32  memory address
- Mem_WrData  out  32  memory write data
- Mem_RdData  in  32  memory read data, combinational from Mem_Addr

## Operation
- State:
  - circular array of DEPTH entries, each holding {addr[31:2], data[31:0]}
  - head pointer (oldest entry), tail pointer (next free slot)
  - count, range 0..DEPTH, width clog2(DEPTH)+1
  - pointers wrap modulo DEPTH
- Drain condition: drain = (count≠0) && !Ld_Valid.
- Load cycle (Ld_Valid=1):
  - Mem_Rd=1, Mem_Wr=0, Mem_Addr=Ld_Addr, Mem_WrData=0.
  - Ld_Data = data of the youngest valid entry whose addr equals Ld_Addr[31:2]. The search runs from tail−1 back toward head, with wrap.
  - If no entry matches, Ld_Data = Mem_RdData.
- Drain cycle (drain=1):
  - Mem_Rd=0, Mem_Wr=1, Mem_Addr={head.addr,2'b00}, Mem_WrData=head.data.
  - At the edge, head advances by 1 and count decrements.
- Idle cycle (neither load nor drain): Mem_Rd=Mem_Wr=0, Mem_Addr=0, Mem_WrData=0, Ld_Data=0.
- Ld_Data=0 whenever Ld_Valid=0.
- St_Ready = (count<DEPTH) || drain. Pushing while full is legal only in a drain cycle.
- Accepted store (St_Valid && St_Ready): entry[tail] is written, tail advances, count increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- St_Valid and Ld_Valid both high:
  - The load is serviced, so no drain occurs.
  - The store is pushed if count<DEPTH.
  - The load does not see the same-cycle store; it sees buffer contents before the edge.
- Duplicate addresses are kept as separate entries. Program order is preserved in memory because drain is strictly FIFO.
- Empty = (count==0).
- Reset (rst low): count=0, head=tail=0, entry contents don't-care. Pending stores are discarded.
- Reset output values: St_Ready=1, Stall=0, Empty=1, Mem_Wr=0. With Ld_Valid=0: Mem_Rd=0, Mem_Addr=0, Ld_Data=0.

## Timing
- Ld_Data is combinational from Ld_Addr, buffer contents and Mem_RdData, with zero cycles of latency. No register is added in the load path.
- A store accepted at edge N is written to memory at the earliest at edge N+1, provided cycle N+1 has no load.
- Drain throughput is one store per load-free cycle.
- Continuous loads starve the drain indefinitely. This is intended; the pipeline resolves it through Stall.
- Stall depends combinationally on St_Valid, count and Ld_Valid.
- rst assertion takes effect immediately (asynchronously) and Mem_Wr falls in the same instant. Release is synchronous to the next edge.

## Test plan
- Reset: hold rst low with random inputs and Ld_Valid=0 → St_Ready=1, Stall=0, Empty=1, Mem_Wr=0, Mem_Rd=0, Ld_Data=0.
- Single store: store 0x00000010 ← 0xDEADBEEF, then idle → next cycle Mem_Wr=1, Mem_Addr=0x10, Mem_WrData=0xDEADBEEF; following cycle Empty=1.
- Forwarding:
  - Hold Ld_Valid=1 at 0x100 while storing 0x20←0xA and then 0x20←0xB.
  - Load 0x20 with Mem_RdData=0x5555 → Ld_Data=0xB.
  - Load 0x24 → Ld_Data=Mem_RdData.
  - Load 0x22 (same word) → Ld_Data=0xB.
- Full buffer:
  - Under continuous loads, store 4 entries → St_Ready=0, and a 5th St_Valid gives Stall=1.
  - Drop Ld_Valid → St_Ready=1, the 5th store is accepted in the same cycle as the head drains, and count stays 4.
- Wrap-around: issue 10 stores to distinct addresses 0x40+4k with loads on alternate cycles → memory writes occur in exact issue order, no entries are lost, and Empty=1 at the end.
- Reset mid-operation: with 3 entries buffered, pull rst low mid-cycle → Mem_Wr drops immediately, Empty=1, and after release no further memory writes occur.
